axi_bresp_arb: RTL and testbench

AXI_BRESP_ARB -- requirements
Module: axi_bresp_arb

---
 rtl/axi_bresp_arb.sv | 206 ++++++++++++++++++++
 tb/tb_axi_bresp_arb.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_bresp_arb.sv
// axi_bresp_arb
// Merges memory-side B responses with locally generated DECERR responses for
// dropped AW transactions into a single registered master-side B channel.
// A round-robin grant picks between the two sources when both are pending.
// An outstanding-write counter tracks AWs forwarded to memory, and throttles
// upstream issue through out_aw_stall.
//
// Ports
//   clk, reset                          : clock, synchronous active-high reset
//   in_mb{id,resp,user,valid}, out_mbready : memory-side B channel
//   in_drop, in_awid, in_awuser, out_drop_full : dropped-AW capture queue
//   in_aw_issue, out_aw_stall, out_outst_cnt   : outstanding-write tracking
//   out_sb{id,resp,user,valid}, in_sbready     : master-side B channel (registered)
//   out_err                             : sticky error (drop overflow, counter under/overflow)
module axi_bresp_arb #(
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 2,
  parameter int DROP_DEPTH = 4,
  parameter int MAX_OUTST  = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ID_WIDTH-1:0]            in_mbid,
  input  logic [1:0]                     in_mbresp,
  input  logic [USER_WIDTH-1:0]          in_mbuser,
  input  logic                           in_mbvalid,
  output logic                           out_mbready,
  input  logic                           in_drop,
  input  logic [ID_WIDTH-1:0]            in_awid,
  input  logic [USER_WIDTH-1:0]          in_awuser,
  output logic                           out_drop_full,
  input  logic                           in_aw_issue,
  output logic                           out_aw_stall,
  output logic [ID_WIDTH-1:0]            out_sbid,
  output logic [1:0]                     out_sbresp,
  output logic [USER_WIDTH-1:0]          out_sbuser,
  output logic                           out_sbvalid,
  input  logic                           in_sbready,
  output logic [$clog2(MAX_OUTST+1)-1:0] out_outst_cnt,
  output logic                           out_err
);

  localparam int PTR_W = $clog2(DROP_DEPTH);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int ENT_W = ID_WIDTH + USER_WIDTH;

  localparam logic [PTR_W:0]   DEPTH_Q   = DROP_DEPTH[PTR_W:0];
  localparam logic [CNT_W-1:0] MAX_CNT   = MAX_OUTST[CNT_W-1:0];
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
  localparam logic [PTR_W:0]   QCNT_ONE  = (PTR_W + 1)'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

  // Slot states; the state bit is driven straight out as out_sbvalid.
  localparam logic [0:0] SLOT_EMPTY = 1'b0;
  localparam logic [0:0] SLOT_FULL  = 1'b1;

  localparam logic GRANT_MEM  = 1'b0;
  localparam logic GRANT_DROP = 1'b1;

  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [ENT_W-1:0]      q_mem [DROP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        q_cnt;
  logic                  q_empty;
  logic                  q_full;
  logic [ENT_W-1:0]      q_head;

  logic [0:0]            slot_state;
  logic [ID_WIDTH-1:0]   sb_id;
  logic [1:0]            sb_resp;
  logic [USER_WIDTH-1:0] sb_user;
  logic                  last_grant;

  logic                  can_load;
  logic                  mem_turn;
  logic                  mem_load;
  logic                  drop_load;
  logic                  push;
  logic                  drop_ovf;

  logic [CNT_W-1:0]      outst_cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic                  cnt_err;
  logic                  err_flag;

  assign q_empty = (q_cnt == {(PTR_W + 1){1'b0}});
  assign q_full  = (q_cnt == DEPTH_Q);
  assign q_head  = q_mem[rd_ptr];

  // The slot accepts a new response when empty or when its current one is
  // being taken this cycle.
  assign can_load = (slot_state == SLOT_EMPTY) || in_sbready;

  // MEM owns the grant unless DROP is pending and MEM went last. Keeping
  // in_mbvalid out of this term keeps out_mbready independent of valid; a
  // lone DROP source still loads because mem_load stays low without valid.
  assign mem_turn    = q_empty || (last_grant == GRANT_DROP);
  assign out_mbready = !reset && can_load && mem_turn;
  assign mem_load    = in_mbvalid && out_mbready;
  assign drop_load   = !reset && can_load && !q_empty && !mem_load;

  // A full queue still takes a push when the head leaves in the same cycle.
  assign push     = !reset && in_drop && (!q_full || drop_load);
  assign drop_ovf = !reset && in_drop && q_full && !drop_load;

  // Next outstanding count with saturation and under/overflow detection.
  always_comb begin
    cnt_next = outst_cnt;
    cnt_err  = 1'b0;
    case ({in_aw_issue && !reset, mem_load})
      2'b10: begin
        if (outst_cnt == MAX_CNT) begin
          cnt_err = 1'b1;
        end else begin
          cnt_next = outst_cnt + CNT_ONE;
        end
      end
      2'b01: begin
        if (outst_cnt == {CNT_W{1'b0}}) begin
          cnt_err = 1'b1;
        end else begin
          cnt_next = outst_cnt - CNT_ONE;
        end
      end
      default: cnt_next = outst_cnt;
    endcase
  end

  // Drop queue storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wr_ptr] <= {in_awid, in_awuser};
    end
  end

  // Drop queue pointers and occupancy; pointers wrap naturally (depth is 2^n).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      q_cnt  <= {(PTR_W + 1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (drop_load) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, drop_load})
        2'b10:   q_cnt <= q_cnt + QCNT_ONE;
        2'b01:   q_cnt <= q_cnt - QCNT_ONE;
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // Output slot and round-robin history.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_state <= SLOT_EMPTY;
      sb_id      <= {ID_WIDTH{1'b0}};
      sb_resp    <= 2'b00;
      sb_user    <= {USER_WIDTH{1'b0}};
      last_grant <= GRANT_DROP;
    end else if (mem_load) begin
      slot_state <= SLOT_FULL;
      sb_id      <= in_mbid;
      sb_resp    <= in_mbresp;
      sb_user    <= in_mbuser;
      last_grant <= GRANT_MEM;
    end else if (drop_load) begin
      slot_state <= SLOT_FULL;
      sb_id      <= q_head[ENT_W-1:USER_WIDTH];
      sb_resp    <= RESP_DECERR;
      sb_user    <= q_head[USER_WIDTH-1:0];
      last_grant <= GRANT_DROP;
    end else if (can_load) begin
      slot_state <= SLOT_EMPTY;
    end else begin
      slot_state <= slot_state;
    end
  end

  // Outstanding counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      outst_cnt <= {CNT_W{1'b0}};
      err_flag  <= 1'b0;
    end else begin
      outst_cnt <= cnt_next;
      err_flag  <= err_flag || cnt_err || drop_ovf;
    end
  end

  assign out_sbvalid   = slot_state[0];
  assign out_sbid      = sb_id;
  assign out_sbresp    = sb_resp;
  assign out_sbuser    = sb_user;
  assign out_drop_full = q_full;
  assign out_outst_cnt = outst_cnt;
  assign out_aw_stall  = (outst_cnt == MAX_CNT);
  assign out_err       = err_flag;

endmodule

// File: tb/tb_axi_bresp_arb.sv
// Testbench for axi_bresp_arb: directed scenario tasks plus a scoreboard that
// compares every master-side B handshake against queued expected responses.
module tb_axi_bresp_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_mbid;
  logic [1:0] in_mbresp;
  logic [1:0] in_mbuser;
  logic       in_mbvalid;
  logic       out_mbready;
  logic       in_drop;
  logic [7:0] in_awid;
  logic [1:0] in_awuser;
  logic       out_drop_full;
  logic       in_aw_issue;
  logic       out_aw_stall;
  logic [7:0] out_sbid;
  logic [1:0] out_sbresp;
  logic [1:0] out_sbuser;
  logic       out_sbvalid;
  logic       in_sbready;
  logic [6:0] out_outst_cnt;
  logic       out_err;

  int checks   = 0;
  int failures = 0;

  logic [11:0] exp_q[$];
  logic [11:0] mon_exp;

  axi_bresp_arb dut (
    .clk(clk), .reset(reset),
    .in_mbid(in_mbid), .in_mbresp(in_mbresp), .in_mbuser(in_mbuser),
    .in_mbvalid(in_mbvalid), .out_mbready(out_mbready),
    .in_drop(in_drop), .in_awid(in_awid), .in_awuser(in_awuser),
    .out_drop_full(out_drop_full),
    .in_aw_issue(in_aw_issue), .out_aw_stall(out_aw_stall),
    .out_sbid(out_sbid), .out_sbresp(out_sbresp), .out_sbuser(out_sbuser),
    .out_sbvalid(out_sbvalid), .in_sbready(in_sbready),
    .out_outst_cnt(out_outst_cnt), .out_err(out_err)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ent(int id, logic [1:0] resp, int user);
    return {id[7:0], resp, user[1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_mbid = 8'd0; in_mbresp = 2'b00; in_mbuser = 2'd0; in_mbvalid = 1'b0;
    in_drop = 1'b0; in_awid = 8'd0; in_awuser = 2'd0; in_aw_issue = 1'b0;
    in_sbready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard: every completed master-side handshake must match the queue head.
  always @(negedge clk) begin
    if (!reset && out_sbvalid && in_sbready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got=%h expected=none", {out_sbid, out_sbresp, out_sbuser});
      end else begin
        mon_exp = exp_q.pop_front();
        if ({out_sbid, out_sbresp, out_sbuser} !== mon_exp) begin
          failures++;
          $display("FAIL sb_data got=%h expected=%h", {out_sbid, out_sbresp, out_sbuser}, mon_exp);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    in_drop = 1'b1; in_aw_issue = 1'b1; in_mbvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (out_mbready !== 1'b0) begin failures++; $display("FAIL rst_mbready got=%b expected=0", out_mbready); end
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({out_sbvalid, out_sbid, out_sbresp, out_sbuser} !== 13'd0) begin
      failures++; $display("FAIL rst_slot got=%h expected=0", {out_sbvalid, out_sbid, out_sbresp, out_sbuser});
    end
    checks++;
    if ({out_drop_full, out_aw_stall, out_err, out_outst_cnt} !== 10'd0) begin
      failures++; $display("FAIL rst_flags got=%h expected=0", {out_drop_full, out_aw_stall, out_err, out_outst_cnt});
    end
    tick();
    idle_inputs();
    reset = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({out_sbvalid, out_drop_full, out_outst_cnt} !== 9'd0) begin
      failures++; $display("FAIL rst_release got=%h expected=0", {out_sbvalid, out_drop_full, out_outst_cnt});
    end
  endtask

  task automatic test_mem_basic();
    do_reset();
    in_sbready = 1'b1;
    in_aw_issue = 1'b1;
    repeat (3) tick();
    in_aw_issue = 1'b0;
    exp_q.push_back(ent(5, 2'b00, 1));
    in_mbvalid = 1'b1; in_mbid = 8'd5; in_mbresp = 2'b00; in_mbuser = 2'd1;
    @(negedge clk);
    checks++;
    if ({out_mbready, out_sbvalid, out_outst_cnt} !== {1'b1, 1'b0, 7'd3}) begin
      failures++; $display("FAIL basic_pre got=%h expected=%h", {out_mbready, out_sbvalid, out_outst_cnt}, {1'b1, 1'b0, 7'd3});
    end
    tick();
    in_mbvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_sbvalid, out_sbid, out_outst_cnt} !== {1'b1, 8'd5, 7'd2}) begin
      failures++; $display("FAIL basic_latency got=%h expected=%h", {out_sbvalid, out_sbid, out_outst_cnt}, {1'b1, 8'd5, 7'd2});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({out_sbvalid, exp_q.size() == 0} !== 2'b01) begin
      failures++; $display("FAIL basic_drain valid=%b pending=%0d expected valid=0 pending=0", out_sbvalid, exp_q.size());
    end
  endtask

  task automatic test_drop_and_mem();
    do_reset();
    in_sbready = 1'b1;
    in_aw_issue = 1'b1;
    repeat (2) tick();
    in_aw_issue = 1'b0;
    exp_q.push_back(ent(4, 2'b00, 3));
    exp_q.push_back(ent(9, 2'b11, 2));
    in_drop = 1'b1; in_awid = 8'd9; in_awuser = 2'd2;
    in_mbvalid = 1'b1; in_mbid = 8'd4; in_mbresp = 2'b00; in_mbuser = 2'd3;
    tick();
    in_drop = 1'b0; in_mbvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_sbvalid, out_sbid, out_sbresp} !== {1'b1, 8'd4, 2'b00}) begin
      failures++; $display("FAIL both_first got=%h expected=%h", {out_sbvalid, out_sbid, out_sbresp}, {1'b1, 8'd4, 2'b00});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({out_sbvalid, out_sbid, out_sbresp} !== {1'b1, 8'd9, 2'b11}) begin
      failures++; $display("FAIL both_second got=%h expected=%h", {out_sbvalid, out_sbid, out_sbresp}, {1'b1, 8'd9, 2'b11});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({out_sbvalid, out_outst_cnt, out_err, exp_q.size() == 0} !== {1'b0, 7'd1, 1'b0, 1'b1}) begin
      failures++; $display("FAIL both_end valid=%b cnt=%0d err=%b pending=%0d expected 0/1/0/0", out_sbvalid, out_outst_cnt, out_err, exp_q.size());
    end
  endtask

  task automatic test_stall_alternate();
    int  idx;
    int  guard;
    logic hs;
    do_reset();
    in_aw_issue = 1'b1;
    repeat (3) tick();
    in_aw_issue = 1'b0;
    exp_q.push_back(ent(20, 2'b11, 0));
    exp_q.push_back(ent(30, 2'b00, 2));
    exp_q.push_back(ent(21, 2'b11, 1));
    exp_q.push_back(ent(31, 2'b01, 3));
    exp_q.push_back(ent(22, 2'b11, 2));
    exp_q.push_back(ent(32, 2'b00, 0));
    for (int i = 0; i < 3; i++) begin
      in_drop = 1'b1; in_awid = 8'(20 + i); in_awuser = 2'(i);
      tick();
    end
    in_drop = 1'b0;
    in_mbvalid = 1'b1; in_mbid = 8'd30; in_mbresp = 2'b00; in_mbuser = 2'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({out_sbvalid, out_sbid, out_sbresp, out_sbuser} !== {1'b1, 8'd20, 2'b11, 2'd0}) begin
        failures++; $display("FAIL stall_hold cyc=%0d got=%h expected=%h", i, {out_sbvalid, out_sbid, out_sbresp, out_sbuser}, {1'b1, 8'd20, 2'b11, 2'd0});
      end
      checks++;
      if (out_mbready !== 1'b0) begin failures++; $display("FAIL stall_mbready cyc=%0d got=%b expected=0", i, out_mbready); end
      tick();
    end
    in_sbready = 1'b1;
    idx = 0;
    guard = 0;
    while (idx < 3 && guard < 20) begin
      in_mbvalid = 1'b1; in_mbid = 8'(30 + idx);
      in_mbresp = (idx == 1) ? 2'b01 : 2'b00; in_mbuser = 2'(30 + idx);
      @(negedge clk);
      hs = in_mbvalid && out_mbready;
      tick();
      if (hs) idx++;
      guard++;
    end
    in_mbvalid = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin tick(); guard++; end
    @(negedge clk);
    checks++;
    if ({idx == 3, exp_q.size() == 0, out_outst_cnt, out_err} !== {1'b1, 1'b1, 7'd0, 1'b0}) begin
      failures++; $display("FAIL alt_end mem_done=%0d pending=%0d cnt=%0d err=%b expected 3/0/0/0", idx, exp_q.size(), out_outst_cnt, out_err);
    end
  endtask

  task automatic test_drop_overflow();
    int guard;
    do_reset();
    in_aw_issue = 1'b1;
    tick();
    in_aw_issue = 1'b0;
    in_mbvalid = 1'b1; in_mbid = 8'd39; in_mbresp = 2'b00; in_mbuser = 2'd3;
    tick();
    in_mbvalid = 1'b0;
    exp_q.push_back(ent(39, 2'b00, 3));
    exp_q.push_back(ent(40, 2'b11, 0));
    exp_q.push_back(ent(41, 2'b11, 1));
    exp_q.push_back(ent(42, 2'b11, 2));
    exp_q.push_back(ent(43, 2'b11, 3));
    exp_q.push_back(ent(45, 2'b11, 1));
    for (int i = 0; i < 4; i++) begin
      in_drop = 1'b1; in_awid = 8'(40 + i); in_awuser = 2'(i);
      tick();
    end
    in_drop = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_drop_full, out_err, out_sbvalid, out_sbid} !== {1'b1, 1'b0, 1'b1, 8'd39}) begin
      failures++; $display("FAIL ovf_full got=%h expected=%h", {out_drop_full, out_err, out_sbvalid, out_sbid}, {1'b1, 1'b0, 1'b1, 8'd39});
    end
    tick();
    in_drop = 1'b1; in_awid = 8'd44; in_awuser = 2'd0;
    tick();
    in_drop = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_drop_full, out_err} !== 2'b11) begin
      failures++; $display("FAIL ovf_err got=%b expected=11", {out_drop_full, out_err});
    end
    tick();
    in_sbready = 1'b1;
    in_drop = 1'b1; in_awid = 8'd45; in_awuser = 2'd1;
    tick();
    in_drop = 1'b0;
    @(negedge clk);
    checks++;
    if (out_drop_full !== 1'b1) begin failures++; $display("FAIL ovf_pushpop_full got=%b expected=1", out_drop_full); end
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin tick(); guard++; end
    tick();
    @(negedge clk);
    checks++;
    if ({exp_q.size() == 0, out_drop_full, out_sbvalid} !== 3'b100) begin
      failures++; $display("FAIL ovf_drain pending=%0d full=%b valid=%b expected 0/0/0", exp_q.size(), out_drop_full, out_sbvalid);
    end
  endtask

  task automatic test_outst_sat();
    int guard;
    do_reset();
    in_sbready = 1'b1;
    in_aw_issue = 1'b1;
    repeat (63) tick();
    @(negedge clk);
    checks++;
    if ({out_outst_cnt, out_aw_stall} !== {7'd63, 1'b0}) begin
      failures++; $display("FAIL sat_63 cnt=%0d stall=%b expected 63/0", out_outst_cnt, out_aw_stall);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({out_outst_cnt, out_aw_stall, out_err} !== {7'd64, 1'b1, 1'b0}) begin
      failures++; $display("FAIL sat_64 cnt=%0d stall=%b err=%b expected 64/1/0", out_outst_cnt, out_aw_stall, out_err);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({out_outst_cnt, out_aw_stall, out_err} !== {7'd64, 1'b1, 1'b1}) begin
      failures++; $display("FAIL sat_over cnt=%0d stall=%b err=%b expected 64/1/1", out_outst_cnt, out_aw_stall, out_err);
    end
    tick();
    in_aw_issue = 1'b0;
    exp_q.push_back(ent(50, 2'b10, 1));
    exp_q.push_back(ent(51, 2'b00, 2));
    in_mbvalid = 1'b1; in_mbid = 8'd50; in_mbresp = 2'b10; in_mbuser = 2'd1;
    tick();
    in_mbvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_outst_cnt, out_aw_stall} !== {7'd63, 1'b0}) begin
      failures++; $display("FAIL sat_release cnt=%0d stall=%b expected 63/0", out_outst_cnt, out_aw_stall);
    end
    tick();
    in_aw_issue = 1'b1;
    in_mbvalid = 1'b1; in_mbid = 8'd51; in_mbresp = 2'b00; in_mbuser = 2'd2;
    tick();
    in_aw_issue = 1'b0; in_mbvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_outst_cnt !== 7'd63) begin failures++; $display("FAIL sat_both cnt=%0d expected 63", out_outst_cnt); end
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin tick(); guard++; end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL sat_drain pending=%0d expected 0", exp_q.size()); end
  endtask

  task automatic test_underflow();
    int guard;
    do_reset();
    in_sbready = 1'b1;
    exp_q.push_back(ent(70, 2'b00, 2));
    in_mbvalid = 1'b1; in_mbid = 8'd70; in_mbresp = 2'b00; in_mbuser = 2'd2;
    @(negedge clk);
    checks++;
    if (out_mbready !== 1'b1) begin failures++; $display("FAIL und_ready got=%b expected=1", out_mbready); end
    tick();
    in_mbvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_sbvalid, out_outst_cnt, out_err} !== {1'b1, 7'd0, 1'b1}) begin
      failures++; $display("FAIL und_state valid=%b cnt=%0d err=%b expected 1/0/1", out_sbvalid, out_outst_cnt, out_err);
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin tick(); guard++; end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL und_drain pending=%0d expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    in_aw_issue = 1'b1;
    tick();
    in_aw_issue = 1'b0;
    in_mbvalid = 1'b1; in_mbid = 8'd60; in_mbresp = 2'b00; in_mbuser = 2'd0;
    tick();
    in_mbvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_drop = 1'b1; in_awid = 8'(61 + i); in_awuser = 2'(i);
      tick();
    end
    in_drop = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_sbvalid, out_sbid} !== {1'b1, 8'd60}) begin
      failures++; $display("FAIL mid_setup got=%h expected=%h", {out_sbvalid, out_sbid}, {1'b1, 8'd60});
    end
    tick();
    reset = 1'b1;
    in_drop = 1'b1; in_awid = 8'd63; in_aw_issue = 1'b1;
    in_mbvalid = 1'b1; in_mbid = 8'd64;
    @(negedge clk);
    checks++;
    if (out_mbready !== 1'b0) begin failures++; $display("FAIL mid_mbready got=%b expected=0", out_mbready); end
    tick();
    @(negedge clk);
    checks++;
    if ({out_sbvalid, out_sbid, out_drop_full, out_outst_cnt, out_err} !== 18'd0) begin
      failures++; $display("FAIL mid_reset valid=%b id=%0d full=%b cnt=%0d err=%b expected all 0", out_sbvalid, out_sbid, out_drop_full, out_outst_cnt, out_err);
    end
    tick();
    idle_inputs();
    reset = 1'b0;
    in_sbready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_sbvalid !== 1'b0) begin failures++; $display("FAIL mid_no_emit cyc=%0d got=%b expected=0", i, out_sbvalid); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_mem_basic();
    test_drop_and_mem();
    test_stall_alternate();
    test_drop_overflow();
    test_outst_sat();
    test_underflow();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
